// File: rtl/alu_issue_queue.sv
// In-order issue buffer in front of the ALU: forms final operands at enqueue, queues DEPTH ops.
// Latency 1 cycle (0 with ALU_ISSUE_BYPASS_EN defined); in_allowin depends only on occupancy, never on out_allowin.
// Backpressure: a full queue refuses input even in a dequeue cycle; ID holds in_valid until accepted.
module alu_issue_queue #(
    parameter int DEPTH  = 2,
    parameter int DEST_W = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [11:0]              in_alu_control,
    input  logic [31:0]              in_src1,
    input  logic [31:0]              in_src2,
    input  logic [15:0]              in_imm,
    input  logic [4:0]               in_sa,
    input  logic                     in_src1_is_sa,
    input  logic                     in_src2_is_imm,
    input  logic                     in_imm_zext,
    input  logic [DEST_W-1:0]        in_dest,
    output logic                     out_valid,
    input  logic                     out_allowin,
    output logic [11:0]              alu_control,
    output logic [31:0]              alu_src1,
    output logic [31:0]              alu_src2,
    output logic [DEST_W-1:0]        out_dest,
    output logic                     out_bad_op,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [11:0]       ctrl;
        logic [31:0]       src1;
        logic [31:0]       src2;
        logic [DEST_W-1:0] dest;
        logic              bad;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    entry_t formed;
    entry_t sel;
    logic   head_vld;
    logic   q_enq;
    logic   q_deq;
    logic   byp_take;

    function automatic logic is_one_hot(input logic [11:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) n++;
        end
        return n == 1;
    endfunction

    always_comb begin
        formed      = '0;
        formed.ctrl = in_alu_control;
        formed.src1 = in_src1_is_sa ? {27'b0, in_sa} : in_src1;
        if (!in_src2_is_imm) begin
            formed.src2 = in_src2;
        end else if (in_imm_zext) begin
            formed.src2 = {16'b0, in_imm};
        end else begin
            formed.src2 = {{16{in_imm[15]}}, in_imm};
        end
        formed.dest = in_dest;
        // Malformed selects still issue; the flag just travels with the op.
        formed.bad  = !is_one_hot(in_alu_control);
    end

    assign head_vld   = (count_q != '0);
    assign in_allowin = (count_q != FULL_CNT);
    assign q_deq      = head_vld && out_allowin;

`ifdef ALU_ISSUE_BYPASS_EN
    // An empty queue passes the formed op straight through; if EXE takes it, it is never stored.
    assign byp_take = !head_vld && in_valid && out_allowin;
`else
    assign byp_take = 1'b0;
`endif

    assign q_enq = in_valid && in_allowin && !byp_take;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (q_enq) begin
                mem_d[wr_ptr_q] = formed;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (q_deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({q_enq, q_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        sel       = mem_q[rd_ptr_q];
        out_valid = head_vld;
`ifdef ALU_ISSUE_BYPASS_EN
        if (!head_vld && in_valid) begin
            sel       = formed;
            out_valid = 1'b1;
        end
        if (flush) begin
            out_valid = 1'b0;
        end
`endif
        // Fields are zeroed when idle so the ALU never sees stale operands.
        if (out_valid) begin
            alu_control = sel.ctrl;
            alu_src1    = sel.src1;
            alu_src2    = sel.src2;
            out_dest    = sel.dest;
            out_bad_op  = sel.bad;
        end else begin
            alu_control = '0;
            alu_src1    = '0;
            alu_src2    = '0;
            out_dest    = '0;
            out_bad_op  = 1'b0;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue (default DEPTH=2, DEST_W=5); accepted ops are modelled and
// compared in order as EXE consumes them, with per-scenario tasks checking occupancy and boundaries.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_allowin;
    logic [11:0] in_alu_control;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [15:0] in_imm;
    logic [4:0]  in_sa;
    logic        in_src1_is_sa;
    logic        in_src2_is_imm;
    logic        in_imm_zext;
    logic [4:0]  in_dest;
    logic        out_valid;
    logic        out_allowin;
    logic [11:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  out_dest;
    logic        out_bad_op;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        logic        bad;
    } exp_t;

    exp_t sb[$];

    alu_issue_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_allowin     (in_allowin),
        .in_alu_control (in_alu_control),
        .in_src1        (in_src1),
        .in_src2        (in_src2),
        .in_imm         (in_imm),
        .in_sa          (in_sa),
        .in_src1_is_sa  (in_src1_is_sa),
        .in_src2_is_imm (in_src2_is_imm),
        .in_imm_zext    (in_imm_zext),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_allowin    (out_allowin),
        .alu_control    (alu_control),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .out_dest       (out_dest),
        .out_bad_op     (out_bad_op),
        .count          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model();
        exp_t e;
        int   ones;
        e.ctrl = in_alu_control;
        e.s1   = in_src1_is_sa ? {27'd0, in_sa} : in_src1;
        if (!in_src2_is_imm)  e.s2 = in_src2;
        else if (in_imm_zext) e.s2 = {16'd0, in_imm};
        else                  e.s2 = {{16{in_imm[15]}}, in_imm};
        e.dest = in_dest;
        ones = 0;
        for (int i = 0; i < 12; i++) if (in_alu_control[i]) ones++;
        e.bad = (ones != 1);
        return e;
    endfunction

    // Push on acceptance, pop and compare on consumption; same edge handles enqueue before dequeue.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && !flush && in_valid && in_allowin) sb.push_back(model());
        if (resetn && !flush && out_valid && out_allowin) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got op ctrl=%h src1=%h dest=%0d, expected no op", alu_control, alu_src1, out_dest);
            end else begin
                e = sb.pop_front();
                if ({alu_control, alu_src1, alu_src2, out_dest, out_bad_op} !== {e.ctrl, e.s1, e.s2, e.dest, e.bad}) begin
                    n_fail++;
                    $display("FAIL sb_order: got ctrl=%h s1=%h s2=%h dest=%0d bad=%b, expected ctrl=%h s1=%h s2=%h dest=%0d bad=%b",
                             alu_control, alu_src1, alu_src2, out_dest, out_bad_op, e.ctrl, e.s1, e.s2, e.dest, e.bad);
                end
            end
        end
        if (flush || !resetn) sb.delete();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [11:0] ctrl, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [15:0] imm, input logic [4:0] sa, input logic is_sa,
                          input logic is_imm, input logic zext, input logic [4:0] dest);
        in_alu_control = ctrl;
        in_src1        = s1;
        in_src2        = s2;
        in_imm         = imm;
        in_sa          = sa;
        in_src1_is_sa  = is_sa;
        in_src2_is_imm = is_imm;
        in_imm_zext    = zext;
        in_dest        = dest;
    endtask

    task automatic drain();
        int i;
        out_allowin = 1'b1;
        for (i = 0; i < 40 && sb.size() != 0; i++) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d ops still pending, expected 0", sb.size());
        end
        step();
        out_allowin = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
        set_op(12'h0, 32'h0, 32'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || in_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b count=%0d in_allowin=%b, expected 0 0 1", out_valid, count, in_allowin);
        end
        n_checks++;
        if ({alu_control, alu_src1, alu_src2, out_dest, out_bad_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: ctrl=%h s1=%h s2=%h dest=%0d bad=%b, expected all 0", alu_control, alu_src1, alu_src2, out_dest, out_bad_op);
        end
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_op(12'h800, 32'd15, 32'd20, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3);
        in_valid = 1'b1; out_allowin = 1'b1;
        @(negedge clk);
        n_checks++;
`ifdef ALU_ISSUE_BYPASS_EN
        if (out_valid !== 1'b1 || alu_src1 !== 32'd15 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_cycle0: out_valid=%b src1=%0d count=%0d, expected 1 15 0", out_valid, alu_src1, count);
        end
`else
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_cycle0: out_valid=%b count=%0d, expected 0 0", out_valid, count);
        end
`endif
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
`ifdef ALU_ISSUE_BYPASS_EN
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_cycle1: out_valid=%b count=%0d, expected 0 0", out_valid, count);
        end
`else
        if (out_valid !== 1'b1 || alu_src1 !== 32'd15 || alu_src2 !== 32'd20 || out_dest !== 5'd3 ||
            out_bad_op !== 1'b0 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_cycle1: v=%b s1=%0d s2=%0d dest=%0d bad=%b count=%0d, expected 1 15 20 3 0 1",
                     out_valid, alu_src1, alu_src2, out_dest, out_bad_op, count);
        end
`endif
        step();
        @(negedge clk);
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle2: count=%0d out_valid=%b, expected 0 0", count, out_valid);
        end
        out_allowin = 1'b0;
        step();
    endtask

    task automatic test_operands();
        logic [31:0] exp_s1 [3] = '{32'd7, 32'd7, 32'd3};
        logic [31:0] exp_s2 [3] = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'd99};
        out_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      set_op(12'h001, 32'd7, 32'd99, 16'hFFFC, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4);
            else if (k == 1) set_op(12'h002, 32'd7, 32'd99, 16'hFFFC, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);
            else             set_op(12'h004, 32'hDEAD, 32'd99, 16'hFFFC, 5'd3, 1'b1, 1'b0, 1'b0, 5'd6);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || alu_src1 !== exp_s1[k] || alu_src2 !== exp_s2[k]) begin
                n_fail++;
                $display("FAIL operands_%0d: v=%b s1=%h s2=%h, expected 1 %h %h", k, out_valid, alu_src1, alu_src2, exp_s1[k], exp_s2[k]);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        out_allowin = 1'b0;
        set_op(12'h010, 32'hA, 32'hA0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd10);
        in_valid = 1'b1;
        step();
        set_op(12'h020, 32'hB, 32'hB0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd11);
        step();
        set_op(12'h040, 32'hC, 32'hC0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd12);
        @(negedge clk);
        n_checks++;
        if (count !== 2'd2 || in_allowin !== 1'b0 || alu_src1 !== 32'hA) begin
            n_fail++;
            $display("FAIL b2b_full: count=%0d in_allowin=%b head_s1=%h, expected 2 0 a", count, in_allowin, alu_src1);
        end
        step();
        out_allowin = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_allowin !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full_deq: in_allowin=%b, expected 0", in_allowin);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (count !== 2'd1 || in_allowin !== 1'b1 || alu_src1 !== 32'hB) begin
            n_fail++;
            $display("FAIL b2b_after_a: count=%0d in_allowin=%b head_s1=%h, expected 1 1 b", count, in_allowin, alu_src1);
        end
        step();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_wrap();
        out_allowin = 1'b0;
        set_op(12'h100, 32'd100, 32'd0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd20);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            set_op(12'h001 << i, 32'd200 + i, 32'd300 + i, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'(21 + i));
            out_allowin = 1'b1;
            @(negedge clk);
            n_checks++;
            if (count !== 2'd1 || in_allowin !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_%0d: count=%0d in_allowin=%b, expected 1 1", i, count, in_allowin);
            end
            step();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        out_allowin = 1'b0;
        set_op(12'h003, 32'd1, 32'd2, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_bad_op !== 1'b1 || alu_control !== 12'h003) begin
            n_fail++;
            $display("FAIL bad_op: bad=%b ctrl=%h, expected 1 003", out_bad_op, alu_control);
        end
        set_op(12'h008, 32'd3, 32'd4, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8);
        in_valid = 1'b1;
        step();
        set_op(12'h080, 32'd5, 32'd6, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd31);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full: count=%0d out_valid=%b, expected 0 0", count, out_valid);
        end
        set_op(12'h200, 32'd9, 32'd9, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9);
        in_valid = 1'b1;
        step();
        set_op(12'h400, 32'd5, 32'd6, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd30);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one: count=%0d out_valid=%b, expected 0 0", count, out_valid);
        end
        out_allowin = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_allowin = 1'b0;
    endtask

    task automatic test_async_reset();
        out_allowin = 1'b0;
        set_op(12'h001, 32'h11, 32'h22, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1);
        in_valid = 1'b1;
        step();
        set_op(12'h002, 32'h33, 32'h44, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: count=%0d out_valid=%b, expected 2 1", count, out_valid);
        end
        step();
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 ||
            {alu_control, alu_src1, alu_src2, out_dest, out_bad_op} !== '0) begin
            n_fail++;
            $display("FAIL arst_async: v=%b count=%0d ctrl=%h s1=%h s2=%h dest=%0d, expected all 0",
                     out_valid, count, alu_control, alu_src1, alu_src2, out_dest);
        end
        step(); step();
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_allowin !== 1'b1 || count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: in_allowin=%b count=%0d out_valid=%b, expected 1 0 0", in_allowin, count, out_valid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_operands();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
